// File: rtl/alu_control_mc.sv
// ALU control decoder for the RISC-V pipeline. It registers the ALU control code and
// sequences the iterative MUL/DIV/REM unit with a hold/stall down-counter.
module alu_control_mc #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int SCNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [9:0]        funct_i,
  input  logic [2:0]        ALUOp_i,
  output logic              ready_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              ctrl_valid_o,
  output logic              illegal_o,
  output logic              stall_o,
  output logic              done_o,
  output logic [SCNT_W-1:0] stall_cnt_o
);

  localparam int CNT_W = $clog2(255) + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       ill;
    logic       is_mul;
    logic       is_div;
  } dec_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                vld_q, vld_d;
  logic                ill_q, ill_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic                accept_s;
  dec_t                dec_s;

  function automatic dec_t decode(input logic [2:0] op, input logic [9:0] fn);
    dec_t d;
    d = '{code: 4'hF, ill: 1'b1, is_mul: 1'b0, is_div: 1'b0};
    case (op)
      3'b000: begin
        case (fn)
          10'h007: d = '{code: 4'h0, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
          10'h004: d = '{code: 4'h1, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
          10'h001: d = '{code: 4'h2, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
          10'h000: d = '{code: 4'h3, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
          10'h100: d = '{code: 4'h4, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
          10'h008: d = '{code: 4'h5, ill: 1'b0, is_mul: 1'b1, is_div: 1'b0};
          10'h00C: d = '{code: 4'hB, ill: 1'b0, is_mul: 1'b0, is_div: 1'b1};
          10'h00E: d = '{code: 4'hC, ill: 1'b0, is_mul: 1'b0, is_div: 1'b1};
          default: d = '{code: 4'hF, ill: 1'b1, is_mul: 1'b0, is_div: 1'b0};
        endcase
      end
      3'b001: begin
        // I-type ignores funct7 so SRAI's 0x20 funct7 still decodes
        case (fn[2:0])
          3'b000:  d = '{code: 4'h6, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
          3'b101:  d = '{code: 4'h7, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
          3'b001:  d = '{code: 4'hD, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
          default: d = '{code: 4'hF, ill: 1'b1, is_mul: 1'b0, is_div: 1'b0};
        endcase
      end
      3'b010:  d = '{code: 4'h8, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
      3'b011:  d = '{code: 4'h9, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
      3'b100:  d = '{code: 4'hA, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
      default: d = '{code: 4'hF, ill: 1'b1, is_mul: 1'b0, is_div: 1'b0};
    endcase
    return d;
  endfunction

  assign stall_o      = (state_q == BUSY) && (cnt_q != {CNT_W{1'b0}});
  assign done_o       = (state_q == BUSY) && (cnt_q == {CNT_W{1'b0}});
  assign ready_o      = ~stall_o;
  assign ALUCtrl_o    = ctrl_q;
  assign ctrl_valid_o = vld_q;
  assign illegal_o    = ill_q;
  assign stall_cnt_o  = scnt_q;

  assign dec_s    = decode(ALUOp_i, funct_i);
  assign accept_s = valid_i & ready_o & ~flush_i;

  // Next-state: flush beats accept; accept in the done cycle replaces the finished op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    vld_d   = vld_q;
    ill_d   = ill_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
      ctrl_d  = CTRL_W'(4'hF);
      vld_d   = 1'b0;
      ill_d   = 1'b0;
    end else if (accept_s) begin
      ctrl_d = CTRL_W'(dec_s.code);
      vld_d  = 1'b1;
      ill_d  = dec_s.ill;
      if (dec_s.is_mul) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(MUL_LAT - 1);
      end else if (dec_s.is_div) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(DIV_LAT - 1);
      end else begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    end else if (stall_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
      vld_d   = 1'b0;
      ill_d   = 1'b0;
    end
  end

  // Saturating stall-cycle counter, deliberately untouched by flush
  always_comb begin
    scnt_d = scnt_q;
    if (stall_o && (scnt_q != {SCNT_W{1'b1}})) begin
      scnt_d = scnt_q + SCNT_W'(1);
    end else begin
      scnt_d = scnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ctrl_q  <= CTRL_W'(4'hF);
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
      scnt_q  <= {SCNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      vld_q   <= vld_d;
      ill_q   <= ill_d;
      scnt_q  <= scnt_d;
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed testbench for alu_control_mc with default parameters (MUL_LAT=3, DIV_LAT=8).
module tb_alu_control_mc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic [9:0]  funct_i;
  logic [2:0]  ALUOp_i;
  logic        ready_o;
  logic [3:0]  ALUCtrl_o;
  logic        ctrl_valid_o;
  logic        illegal_o;
  logic        stall_o;
  logic        done_o;
  logic [15:0] stall_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  alu_control_mc dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .funct_i      (funct_i),
    .ALUOp_i      (ALUOp_i),
    .ready_o      (ready_o),
    .ALUCtrl_o    (ALUCtrl_o),
    .ctrl_valid_o (ctrl_valid_o),
    .illegal_o    (illegal_o),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic v, input logic [2:0] op, input logic [9:0] fn);
    valid_i = v;
    ALUOp_i = op;
    funct_i = fn;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ctrl"},  32'(ALUCtrl_o),    32'hF);
    check_eq({tag, "_vld"},   32'(ctrl_valid_o), 32'h0);
    check_eq({tag, "_ill"},   32'(illegal_o),    32'h0);
    check_eq({tag, "_stall"}, 32'(stall_o),      32'h0);
    check_eq({tag, "_done"},  32'(done_o),       32'h0);
    check_eq({tag, "_scnt"},  32'(stall_cnt_o),  32'h0);
    check_eq({tag, "_ready"}, 32'(ready_o),      32'h1);
  endtask

  logic [2:0] sw_op   [7] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b011, 3'b100};
  logic [9:0] sw_fn   [7] = '{10'h007, 10'h100, 10'h000, 10'h105, 10'h000, 10'h000, 10'h000};
  logic [3:0] sw_code [7] = '{4'h0, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};

  initial begin
    rst_i   = 1'b0;
    flush_i = 1'b0;
    present(1'b0, 3'b000, 10'h000);
    #12;
    check_reset_vals("rst");
    @(negedge clk_i);
    rst_i = 1'b1;

    // single ADD
    present(1'b1, 3'b000, 10'h000);
    step();
    check_eq("add_ctrl", 32'(ALUCtrl_o), 32'h3);
    check_eq("add_vld", 32'(ctrl_valid_o), 32'h1);
    present(1'b0, 3'b000, 10'h000);
    step();
    check_eq("add_vld_off", 32'(ctrl_valid_o), 32'h0);
    check_eq("add_ctrl_hold", 32'(ALUCtrl_o), 32'h3);

    // back-to-back single-cycle sweep
    for (int i = 0; i < 7; i++) begin
      check_eq("sweep_ready_in", 32'(ready_o), 32'h1);
      present(1'b1, sw_op[i], sw_fn[i]);
      step();
      check_eq("sweep_ctrl", 32'(ALUCtrl_o), 32'(sw_code[i]));
      check_eq("sweep_vld", 32'(ctrl_valid_o), 32'h1);
    end
    check_eq("sweep_ready", 32'(ready_o), 32'h1);

    // MUL, 3 cycles
    present(1'b1, 3'b000, 10'h008);
    step();
    present(1'b0, 3'b000, 10'h000);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      check_eq("mul_ctrl", 32'(ALUCtrl_o), 32'h5);
      check_eq("mul_vld", 32'(ctrl_valid_o), 32'h1);
      check_eq("mul_stall", 32'(stall_o), (k < 2) ? 32'h1 : 32'h0);
      check_eq("mul_done", 32'(done_o), (k == 2) ? 32'h1 : 32'h0);
      check_eq("mul_ready", 32'(ready_o), (k == 2) ? 32'h1 : 32'h0);
    end
    check_eq("mul_scnt", 32'(stall_cnt_o), 32'd2);

    // DIV accepted in MUL's done cycle, 8 cycles
    present(1'b1, 3'b000, 10'h00C);
    step();
    present(1'b0, 3'b000, 10'h000);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      check_eq("div_ctrl", 32'(ALUCtrl_o), 32'hB);
      check_eq("div_vld", 32'(ctrl_valid_o), 32'h1);
      check_eq("div_stall", 32'(stall_o), (k < 7) ? 32'h1 : 32'h0);
      check_eq("div_done", 32'(done_o), (k == 7) ? 32'h1 : 32'h0);
    end
    step();
    check_eq("div_end_vld", 32'(ctrl_valid_o), 32'h0);
    check_eq("div_end_done", 32'(done_o), 32'h0);
    check_eq("div_scnt", 32'(stall_cnt_o), 32'd9);

    // illegal ops
    present(1'b1, 3'b111, 10'h000);
    step();
    check_eq("ill_op_ctrl", 32'(ALUCtrl_o), 32'hF);
    check_eq("ill_op_ill", 32'(illegal_o), 32'h1);
    check_eq("ill_op_stall", 32'(stall_o), 32'h0);
    present(1'b1, 3'b000, 10'h3FF);
    step();
    check_eq("ill_fn_ctrl", 32'(ALUCtrl_o), 32'hF);
    check_eq("ill_fn_ill", 32'(illegal_o), 32'h1);
    check_eq("ill_fn_stall", 32'(stall_o), 32'h0);
    present(1'b0, 3'b000, 10'h000);
    step();
    check_eq("ill_clr", 32'(illegal_o), 32'h0);
    check_eq("ill_clr_vld", 32'(ctrl_valid_o), 32'h0);

    // flush in 2nd DIV cycle with an ADD presented
    present(1'b1, 3'b000, 10'h00C);
    step();
    check_eq("fl_div_ctrl", 32'(ALUCtrl_o), 32'hB);
    present(1'b0, 3'b000, 10'h000);
    step();
    check_eq("fl_div_stall", 32'(stall_o), 32'h1);
    flush_i = 1'b1;
    present(1'b1, 3'b000, 10'h000);
    step();
    flush_i = 1'b0;
    present(1'b0, 3'b000, 10'h000);
    check_eq("fl_vld", 32'(ctrl_valid_o), 32'h0);
    check_eq("fl_ctrl", 32'(ALUCtrl_o), 32'hF);
    check_eq("fl_ready", 32'(ready_o), 32'h1);
    check_eq("fl_stall", 32'(stall_o), 32'h0);
    check_eq("fl_scnt", 32'(stall_cnt_o), 32'd11);
    step();
    check_eq("fl_noadd_ctrl", 32'(ALUCtrl_o), 32'hF);
    check_eq("fl_noadd_vld", 32'(ctrl_valid_o), 32'h0);

    // async reset mid-REM
    present(1'b1, 3'b000, 10'h00E);
    step();
    check_eq("rem_ctrl", 32'(ALUCtrl_o), 32'hC);
    check_eq("rem_stall", 32'(stall_o), 32'h1);
    present(1'b0, 3'b000, 10'h000);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_vals("arst");
    #3;
    rst_i = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_mc.md
# alu_control_mc

Parametrised, multi-cycle-aware ALU control unit for the pipelined RISC-V core. Decodes `{funct7,funct3}` and the 3-bit ALUOp from ID/EX into a registered ALU control code. It also sequences the iterative MUL/DIV/REM datapath: the code is held for the operation's latency and a stall is raised toward the hazard unit. It sits between the ID/EX register and the ALU, alongside the hazard detection unit.

## Interface
- `CTRL_W`, default 4: ALU control code width, ≥4; codes are zero-extended.
- `MUL_LAT`, default 3: MUL occupancy in cycles, 1..255.
- `DIV_LAT`, default 8: DIV/REM occupancy in cycles, 1..255.
- `SCNT_W`, default 16: stall-cycle counter width.
- `clk_i` in 1: rising-edge clock.
- `rst_i` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous pipeline flush; highest priority.
- `valid_i` in 1: an instruction is presented.
- `funct_i` in 10: `{funct7, funct3}`.
- `ALUOp_i` in 3: 000 R, 001 I, 010 LW, 011 SW, 100 BEQ; other values are illegal.
- `ready_o` out 1: can accept this cycle; `ready_o = ~stall_o`.
- `ALUCtrl_o` out CTRL_W: registered control code.
- `ctrl_valid_o` out 1: `ALUCtrl_o` is meaningful this cycle.
- `illegal_o` out 1: the current code came from an undecodable op.
- `stall_o` out 1: multi-cycle op in progress with more than 0 cycles remaining.
- `done_o` out 1: final cycle of a multi-cycle op.
- `stall_cnt_o` out SCNT_W: saturating count of cycles with `stall_o` high.

## Operation
- Code map (hex):
  - R-type, funct_i → code: 0x007 AND→0, 0x004 XOR→1, 0x001 SLL→2, 0x000 ADD→3, 0x100 SUB→4, 0x008 MUL→5, 0x00C DIV→B, 0x00E REM→C.
  - I-type uses funct3 only: 000 ADDI→6, 101 SRAI→7, 001 SLLI→D.
  - LW→8, SW→9, BEQ→A.
  - Anything else→F, with `illegal_o`=1.
- Multi-cycle ops: MUL uses latency MUL_LAT; DIV and REM use DIV_LAT. All other codes, including illegal, are single-cycle.
- FSM states:
  - IDLE: `ready_o`=1.
  - BUSY: down-counter `cnt` of width clog2(255)+1.
- Accept condition: `valid_i & ready_o & ~flush_i` at a rising edge.
  - After the edge: `ALUCtrl_o`=code, `ctrl_valid_o`=1, `illegal_o` per decode.
  - Single-cycle op: state becomes IDLE.
  - Multi-cycle op: state becomes BUSY with `cnt`=LAT−1.
- BUSY: `ALUCtrl_o`, `ctrl_valid_o` and `illegal_o` are held.
  - `cnt` decrements each edge.
  - `done_o = (state==BUSY) & (cnt==0)`.
  - `stall_o = (state==BUSY) & (cnt!=0)`.
- Back-to-back: a new op may be accepted in the `done_o` cycle, and it replaces the finished op at that edge. With no new accept, the next edge leaves `ctrl_valid_o`=0 in IDLE.
- IDLE with no accept: `ctrl_valid_o`=0 and `illegal_o`=0 from the next edge. `ALUCtrl_o` holds its last value.
- `flush_i`: on the next edge, state becomes IDLE, `cnt`=0, `ctrl_valid_o`=0, `illegal_o`=0, `ALUCtrl_o`=F. Any simultaneous `valid_i` is dropped. `stall_cnt_o` is not cleared.
- `stall_cnt_o` increments on each edge where `stall_o`=1 and saturates at all-ones.

## Timing
- Reset (asynchronous, `rst_i`=0) forces:
  - state IDLE, `cnt`=0
  - `ALUCtrl_o`=F, `ctrl_valid_o`=0, `illegal_o`=0
  - `stall_o`=0, `done_o`=0, `stall_cnt_o`=0, `ready_o`=1
- These values hold while `rst_i` is low. Reset asserted mid-BUSY aborts the op immediately.
- Latency is 1 cycle from the accept edge to a valid `ALUCtrl_o`.
- A multi-cycle op holds `ctrl_valid_o` for exactly LAT cycles:
  - `stall_o` is high for the first LAT−1 cycles.
  - `done_o` is high in the last cycle.
  - LAT=1 gives no stall and `done_o` in the first cycle.
- `ready_o`, `stall_o` and `done_o` are combinational from state and `cnt` only; there is no input→output combinational path.
- Throughput is one single-cycle op per clock.

## Test plan
- Reset, then single-cycle decode: hold `rst_i`=0 and check all outputs equal their reset values. Release reset, then present ADD (ALUOp=000, funct=0x000) for 1 cycle → next cycle `ALUCtrl_o`=3, `ctrl_valid_o`=1; following cycle `ctrl_valid_o`=0.
- Single-cycle sweep: back-to-back AND, SUB, ADDI, SRAI, LW, SW, BEQ on consecutive cycles → codes 0, 4, 6, 7, 8, 9, A on consecutive cycles; `ready_o` stays 1.
- MUL with MUL_LAT=3 → 3 cycles of `ALUCtrl_o`=5.
  - `stall_o`=1,1,0 and `done_o`=0,0,1 across those cycles.
  - `stall_cnt_o` increases by 2.
  - A DIV presented during the `done_o` cycle is accepted, giving 8 cycles of code B.
- Illegal inputs: ALUOp=111, then R-type funct 0x3FF → code F with `illegal_o`=1 for 1 cycle each; no stall.
- Flush in BUSY: `flush_i` in the 2nd cycle of a DIV, with `valid_i`=1 presenting ADD → next cycle IDLE, `ctrl_valid_o`=0, `ALUCtrl_o`=F, the ADD is not issued, `ready_o`=1.
- Async reset mid-REM: drop `rst_i` between clock edges → outputs reach reset values without a clock edge; `stall_cnt_o`=0.
